// File: rtl/uart_transmitter_if.sv
// Host-side byte handshake and serial line status of the UART transmitter.
// The host drives the master side; the transmitter implements the slave side.
interface uart_transmitter_if;
   logic       i_tx_dv;
   logic [7:0] i_tx_byte;
   logic       o_tx_ready;
   logic       o_tx_serial;
   logic       o_tx_active;
   logic       o_tx_done;

   modport master (
      output i_tx_dv,
      output i_tx_byte,
      input  o_tx_ready,
      input  o_tx_serial,
      input  o_tx_active,
      input  o_tx_done
   );

   modport slave (
      input  i_tx_dv,
      input  i_tx_byte,
      output o_tx_ready,
      output o_tx_serial,
      output o_tx_active,
      output o_tx_done
   );
endinterface

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Frames are sent back to back while the FIFO holds data.
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   uart_transmitter_if.slave tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LP_BIT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   LP_FULL     = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_serial;
   logic          r_done;

   logic          w_serial_nxt;
   logic          w_done_nxt;
   logic          w_pop;
   logic          w_push;
   logic          w_bit_end;
   logic          w_empty;
   logic          w_ready;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   assign w_ready   = (r_count != LP_FULL);
   assign w_empty   = (r_count == '0);
   assign w_push    = tx.i_tx_dv & w_ready;
   assign w_bit_end = (r_cnt == LP_BIT_LAST);

   assign tx.o_tx_ready  = w_ready;
   assign tx.o_tx_serial = r_serial;
   assign tx.o_tx_done   = r_done;
   assign tx.o_tx_active = (r_state != S_IDLE);

   // Byte storage is not reset; occupancy alone defines what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx.i_tx_byte;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_bit_end && (r_bit_idx == 3'd7)) begin
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_state_nxt = w_empty ? S_IDLE : S_START;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next value of the registered line, done strobe and FIFO pop.
   always_comb begin
      w_serial_nxt = r_serial;
      w_done_nxt   = 1'b0;
      w_pop        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_serial_nxt = 1'b1;
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_serial_nxt = 1'b0;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_serial_nxt = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
                  w_serial_nxt = 1'b1;
               end else begin
                  w_serial_nxt = r_shift[r_bit_idx + 3'd1];
               end
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_done_nxt = 1'b1;
               if (!w_empty) begin
                  w_pop        = 1'b1;
                  w_serial_nxt = 1'b0;
               end else begin
                  w_serial_nxt = 1'b1;
               end
            end
         end
         default: w_serial_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_serial <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_serial <= w_serial_nxt;
         r_done   <= w_done_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if ((w_state_nxt != r_state) || w_bit_end ||
                   (r_state == S_IDLE)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
         end
         if ((r_state == S_START) && w_bit_end) begin
            r_bit_idx <= '0;
         end else if ((r_state == S_DATA) && w_bit_end) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// A line-level receiver model collects the bytes actually framed on the wire.
module tb_uart_transmitter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int n_done = 0;
   int stop_err = 0;

   logic [7:0] rx_q [$];

   uart_transmitter_if u_if ();

   uart_transmitter #(
      .CLKS_PER_BIT(8),
      .FIFO_DEPTH  (4)
   ) u_dut (
      .i_clk(clk),
      .i_rst(rst),
      .tx   (u_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Counted on the rising edge so readers at the falling edge never race it.
   always @(posedge clk) begin
      if (u_if.o_tx_done === 1'b1) begin
         n_done++;
      end
   end

   // Receiver: find start fall, sample each bit near its centre.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (!rst && u_if.o_tx_serial === 1'b0) begin
            repeat (3) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (8) @(negedge clk);
               b[i] = u_if.o_tx_serial;
            end
            repeat (8) @(negedge clk);
            if (u_if.o_tx_serial !== 1'b1) begin
               stop_err++;
            end
            rx_q.push_back(b);
         end
      end
   end

   initial begin
      logic [9:0] frame;
      logic [9:0] got;
      logic [5:0] rdy;
      logic [7:0] b31 [6];
      logic [7:0] b35 [6];
      logic [7:0] b33 [3];
      int bad;
      int early;
      int d0;

      b31 = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'h3C};
      b35 = '{8'hC3, 8'h5A, 8'h7E, 8'h01, 8'h96, 8'hE8};
      b33 = '{8'h81, 8'h12, 8'h34};

      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'h00;

      #1 rst = 1'b1;
      #1;
      check("rst_serial", u_if.o_tx_serial, 1);
      check("rst_ready",  u_if.o_tx_ready, 1);
      check("rst_active", u_if.o_tx_active, 0);
      check("rst_done",   u_if.o_tx_done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Quiet line with no host traffic.
      bad = 0;
      d0  = n_done;
      repeat (1000) begin
         @(negedge clk);
         if (u_if.o_tx_serial !== 1'b1 || u_if.o_tx_ready !== 1'b1) bad++;
      end
      check("idle_line", bad, 0);
      check("idle_done", n_done - d0, 0);

      // Single byte 0xA5 from idle.
      frame = {1'b1, 8'hA5, 1'b0};
      u_if.i_tx_dv   = 1'b1;
      u_if.i_tx_byte = 8'hA5;
      @(negedge clk);
      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'h00;
      check("accept_edge_line", u_if.o_tx_serial, 1);
      @(negedge clk);
      check("start_fall", u_if.o_tx_serial, 0);
      check("start_active", u_if.o_tx_active, 1);
      bad   = 0;
      early = 0;
      got   = '0;
      for (int c = 0; c < 80; c++) begin
         if (u_if.o_tx_serial !== frame[c/8]) bad++;
         if (u_if.o_tx_done !== 1'b0) early++;
         if (c % 8 == 4) got[c/8] = u_if.o_tx_serial;
         @(negedge clk);
      end
      check("a5_bits", got, frame);
      check("a5_bit_timing", bad, 0);
      check("a5_done_early", early, 0);
      check("a5_done_pulse", u_if.o_tx_done, 1);
      check("a5_end_active", u_if.o_tx_active, 0);
      check("a5_end_line", u_if.o_tx_serial, 1);
      @(negedge clk);
      check("a5_done_once", u_if.o_tx_done, 0);

      // Six-cycle burst: five taken, the sixth refused while full.
      for (int i = 0; i < 6; i++) begin
         u_if.i_tx_dv   = 1'b1;
         u_if.i_tx_byte = b31[i];
         rdy[i] = u_if.o_tx_ready;
         @(negedge clk);
      end
      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'h00;
      check("burst_ready", rdy, 6'b011111);
      repeat (75) @(negedge clk);
      check("full_before_pop", u_if.o_tx_ready, 0);
      @(negedge clk);
      check("ready_after_pop", u_if.o_tx_ready, 1);
      check("b2b_done", u_if.o_tx_done, 1);
      check("b2b_start", u_if.o_tx_serial, 0);
      check("b2b_active", u_if.o_tx_active, 1);
      bad = 0;
      repeat (319) begin
         @(negedge clk);
         if (u_if.o_tx_active !== 1'b1) bad++;
      end
      check("burst_no_gap", bad, 0);
      @(negedge clk);
      check("burst_last_done", u_if.o_tx_done, 1);
      check("burst_idle", u_if.o_tx_active, 0);
      repeat (10) @(negedge clk);
      check("rx_count_1", rx_q.size(), 6);
      check("frames_eq_accepts", n_done, 6);
      if (rx_q.size() == 6) begin
         check("rx_a5", rx_q[0], 8'hA5);
         for (int i = 0; i < 5; i++) begin
            check($sformatf("rx_burst%0d", i), rx_q[i+1], b31[i]);
         end
      end

      // Push coinciding with the stop-end pop at occupancy 3.
      for (int i = 0; i < 4; i++) begin
         u_if.i_tx_dv   = 1'b1;
         u_if.i_tx_byte = b35[i];
         @(negedge clk);
      end
      u_if.i_tx_dv = 1'b0;
      repeat (77) @(negedge clk);
      u_if.i_tx_dv   = 1'b1;
      u_if.i_tx_byte = b35[4];
      check("pre_pop_ready", u_if.o_tx_ready, 1);
      @(negedge clk);
      u_if.i_tx_byte = b35[5];
      check("pushpop_ready", u_if.o_tx_ready, 1);
      check("pushpop_done", u_if.o_tx_done, 1);
      @(negedge clk);
      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'h00;
      check("occ3_plus1_full", u_if.o_tx_ready, 0);
      repeat (420) @(negedge clk);
      check("rx_count_2", rx_q.size(), 12);
      check("frames_2", n_done, 12);
      if (rx_q.size() == 12) begin
         for (int i = 0; i < 6; i++) begin
            check($sformatf("rx_order%0d", i), rx_q[6+i], b35[i]);
         end
      end

      // Reset during data bit 3 of 0x81 with two bytes queued.
      for (int i = 0; i < 3; i++) begin
         u_if.i_tx_dv   = 1'b1;
         u_if.i_tx_byte = b33[i];
         @(negedge clk);
      end
      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'h00;
      repeat (34) @(negedge clk);
      check("bit3_line", u_if.o_tx_serial, 0);
      check("bit3_active", u_if.o_tx_active, 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_line", u_if.o_tx_serial, 1);
      check("midrst_active", u_if.o_tx_active, 0);
      check("midrst_ready", u_if.o_tx_ready, 1);
      check("midrst_done", u_if.o_tx_done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      d0  = n_done;
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (u_if.o_tx_serial !== 1'b1) bad++;
      end
      check("post_rst_line", bad, 0);
      check("post_rst_done", n_done - d0, 0);
      rx_q.delete();

      // Accept on the very first edge after reset release.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      u_if.i_tx_dv   = 1'b1;
      u_if.i_tx_byte = 8'h6C;
      @(negedge clk);
      u_if.i_tx_dv   = 1'b0;
      u_if.i_tx_byte = 8'hFF;
      check("first_edge_line", u_if.o_tx_serial, 1);
      @(negedge clk);
      check("first_edge_fall", u_if.o_tx_serial, 0);
      d0 = n_done;
      repeat (90) @(negedge clk);
      check("first_edge_frames", n_done - d0, 1);
      check("first_edge_rx_n", rx_q.size(), 1);
      if (rx_q.size() == 1) begin
         check("first_edge_rx", rx_q[0], 8'h6C);
      end
      check("stop_bits", stop_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
